// File: rtl/pe_input_loader.sv
// Streams one NUM_VECTORS x VECTOR_SIZE word frame into BRAM (write one cycle after handshake), then pulses pe_start
// and holds s_ready low until pe_done; define PE_LOADER_LAST_CHECK_EN to enable the s_last framing check and err pulse.
module pe_input_loader #(
    parameter int          VECTOR_SIZE     = 64,
    parameter int          NUM_VECTORS     = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          FRAME_CNT_WIDTH = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [31:0]                BRAM_ADDR,
    output logic [31:0]                BRAM_WRDATA,
    output logic [3:0]                 BRAM_WE,
    output logic                       BRAM_CLK,
    output logic                       pe_start,
    input  logic                       pe_done,
    output logic                       err,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    localparam int WORDS = VECTOR_SIZE * NUM_VECTORS;
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam int PAD_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        KICK  = 2'd2,
        BUSY  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
    logic [31:0]                r_addr;
    logic [31:0]                r_wrdata;
    logic [3:0]                 r_we;
    logic                       w_hs;
    logic                       w_at_last;
    logic                       w_early_last;
    logic                       w_frame_done;
    logic [31:0]                w_addr_off;

    assign w_hs         = s_valid && (r_state == LOAD);
    assign w_at_last    = (r_idx == LAST_IDX);
    assign w_frame_done = (r_state == BUSY) && pe_done;
    assign w_addr_off   = {{PAD_W{1'b0}}, r_idx, 2'b00};

`ifdef PE_LOADER_LAST_CHECK_EN
    logic r_err;

    assign w_early_last = w_hs && s_last && !w_at_last;

    // One flag covers both early and missing s_last: they differ only in which side disagrees.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_hs && (s_last != w_at_last);
        end
    end

    assign err = r_err;
`else
    logic w_unused_s_last;

    assign w_unused_s_last = s_last;
    assign w_early_last    = 1'b0;
    assign err             = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= LOAD;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            LOAD: begin
                if (w_hs) begin
                    if (w_early_last) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                    if (w_at_last) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH:   w_state_nxt = KICK;
            KICK:    w_state_nxt = BUSY;
            BUSY: begin
                if (pe_done) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Address and data hold between writes; only the enables drop to zero.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr      <= '0;
            r_wrdata    <= '0;
            r_we        <= 4'h0;
            r_frame_cnt <= '0;
        end else begin
            r_we <= w_hs ? 4'hF : 4'h0;
            if (w_hs) begin
                r_addr   <= BASE_ADDR + w_addr_off;
                r_wrdata <= s_data;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign s_ready     = (r_state == LOAD);
    assign pe_start    = (r_state == KICK);
    assign BRAM_ADDR   = r_addr;
    assign BRAM_WRDATA = r_wrdata;
    assign BRAM_WE     = r_we;
    assign BRAM_CLK    = aclk;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_pe_input_loader.sv
// Randomized and directed stimulus for pe_input_loader, checked cycle by cycle against a frame-level timing model.
module tb_pe_input_loader;

    localparam int          WORDS = 128;
    localparam logic [31:0] BASE  = 32'h0;

    logic        aclk;
    logic        areset;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        BRAM_CLK;
    logic        pe_start;
    logic        pe_done;
    logic        err;
    logic [7:0]  frame_cnt;

    pe_input_loader #(
        .VECTOR_SIZE    (64),
        .NUM_VECTORS    (2),
        .BASE_ADDR      (BASE),
        .FRAME_CNT_WIDTH(8)
    ) u_dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_WRDATA(BRAM_WRDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_CLK   (BRAM_CLK),
        .pe_start   (pe_start),
        .pe_done    (pe_done),
        .err        (err),
        .frame_cnt  (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: words accepted in this frame, cycle of the final word (-1 while loading),
    // completed frames, and the BRAM port contents expected in the current cycle.
    int          m_words;
    int          m_last_cyc;
    int          m_frames;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_words    = 0;
        m_last_cyc = -1;
        m_frames   = 0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_err      = 1'b0;
    endtask

    task automatic check_outputs();
        logic exp_ready;
        logic exp_start;
        exp_ready = (m_last_cyc < 0);
        exp_start = (m_last_cyc >= 0) && (cyc == m_last_cyc + 2);
        chk("s_ready",   32'(s_ready),     32'(exp_ready));
        chk("pe_start",  32'(pe_start),    32'(exp_start));
        chk("bram_we",   32'(BRAM_WE),     m_we ? 32'hF : 32'h0);
        chk("bram_addr", BRAM_ADDR,        m_addr);
        chk("bram_data", BRAM_WRDATA,      m_data);
        chk("err",       32'(err),         32'(m_err));
        chk("frame_cnt", 32'(frame_cnt),   32'(m_frames));
        chk("bram_clk",  32'(BRAM_CLK),    32'(aclk));
    endtask

    // Advance the model by the inputs driven for cycle 'cyc'.
    task automatic model_update();
        logic hs;
        logic nerr;
        hs   = s_valid && (m_last_cyc < 0);
        nerr = 1'b0;
        if (hs) begin
            m_we   = 1'b1;
            m_addr = BASE + 32'(4 * m_words);
            m_data = s_data;
`ifdef PE_LOADER_LAST_CHECK_EN
            nerr = (s_last != (m_words == WORDS - 1));
`endif
            if (m_words == WORDS - 1) begin
                m_last_cyc = cyc;
                m_words    = 0;
            end else if (nerr) begin
                m_words = 0;
            end else begin
                m_words++;
            end
        end else begin
            m_we = 1'b0;
        end
        m_err = nerr;
        if (m_last_cyc >= 0 && cyc >= m_last_cyc + 3 && pe_done) begin
            m_last_cyc = -1;
            m_frames   = (m_frames + 1) % 256;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic done);
        @(posedge aclk);
        #1;
        cyc++;
        check_outputs();
        s_valid = v;
        s_data  = d;
        s_last  = l;
        pe_done = done;
        model_update();
    endtask

    task automatic do_reset(input int ncyc);
        areset  = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        pe_done = 1'b0;
        model_reset();
        #1;
        check_outputs();
        for (int k = 0; k < ncyc; k++) begin
            @(posedge aclk);
            #1;
            cyc++;
            check_outputs();
        end
        areset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && m_last_cyc >= 0; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic full_frame(input logic [31:0] seed, input logic with_last);
        for (int i = 0; i < WORDS; i++) step(1'b1, seed + 32'(i), with_last && (i == WORDS - 1), 1'b0);
    endtask

    initial begin
        areset  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        pe_done = 1'b0;
        #2;
        do_reset(5);

        // Nominal back-to-back frame, then a stalled word held through BUSY.
        full_frame(32'h1000, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 32'hB0B0_0000, 1'b0, 1'b0);
        step(1'b1, 32'hB0B0_0000, 1'b0, 1'b1);
        step(1'b1, 32'hB0B0_0000, 1'b0, 1'b0);

        // Gapped source completes the frame.
        for (int k = 0; k < 2 * WORDS && m_last_cyc < 0; k++) begin
            if (k % 2 == 0) step(1'b1, 32'hC000_0000 + 32'(k), m_words == WORDS - 1, 1'b0);
            else            step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        end
        drain();

        // Early s_last on word 9, then a full frame with s_last missing.
        for (int i = 0; i < 10; i++) step(1'b1, 32'hE000_0000 + 32'(i), i == 9, 1'b0);
        full_frame(32'hF000_0000, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        drain();

        // Minimum-gap frames: pe_done held high, source always valid.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < WORDS + 4; i++) step(1'b1, $urandom, m_words == WORDS - 1, 1'b1);
        end

        // Random traffic with occasional framing errors and spurious pe_done.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 (m_words == WORDS - 1) ^ ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 3) == 0);
        end

        // Mid-frame reset after 50 words, then a clean frame.
        do_reset(2);
        for (int i = 0; i < 50; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        do_reset(2);
        full_frame(32'h5000_0000, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        drain();
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/pe_input_loader.md
# pe_input_loader

Upstream feeder for the convert PE controller. Accepts a stream of 32-bit words and writes one full operand frame (`NUM_VECTORS` × `VECTOR_SIZE` words) into the shared BRAM through its own write port. Once the frame is committed, it pulses `pe_start` to the PE controller and blocks further input until that controller reports `pe_done`. It sits between the host/DMA stream and the BRAM that the PE controller reads.

## Interface
- `VECTOR_SIZE`, 64, words per vector.
- `NUM_VECTORS`, 2, vectors per frame; `WORDS` = `VECTOR_SIZE*NUM_VECTORS` (128).
- `BASE_ADDR`, 32'h0, byte address of frame word 0.
- `FRAME_CNT_WIDTH`, 8, width of `frame_cnt`.

Ports:
- `aclk` in 1: the single clock; all logic on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `s_data` in 32: stream word.
- `s_valid` in 1: stream word valid.
- `s_last` in 1: marks the final word of a frame.
- `s_ready` out 1: loader accepts a word this cycle.
- `BRAM_ADDR` out 32: byte write address, registered.
- `BRAM_WRDATA` out 32: write data, registered.
- `BRAM_WE` out 4: byte enables, registered; `4'hF` or `4'h0`.
- `BRAM_CLK` out 1: equals `aclk`.
- `pe_start` out 1: one-cycle start pulse to the PE controller.
- `pe_done` in 1: PE controller completion; sampled only in BUSY.
- `err` out 1: one-cycle frame-framing error pulse.
- `frame_cnt` out `FRAME_CNT_WIDTH`: completed frames; wraps.

## Operation
- States: LOAD, FLUSH, KICK, BUSY. Reset state is LOAD.
- `s_ready` = (state == LOAD). It is decoded directly from the state register and has no combinational path from `s_valid`.
- A handshake is `s_valid && s_ready`.
- **LOAD:** on each handshake:
  - Register `BRAM_WE` = `4'hF`, `BRAM_ADDR` = `BASE_ADDR + 4*idx`, `BRAM_WRDATA` = `s_data`.
  - Increment `idx`, a `$clog2(WORDS)+1`-bit counter.
  - When the accepted word has `idx == WORDS-1`, go to FLUSH.
- In any cycle without a handshake, `BRAM_WE` = 0. `BRAM_ADDR` and `BRAM_WRDATA` hold their previous values.
- **FLUSH:** one cycle, during which the last write is on the port. Then go to KICK.
- **KICK:** `pe_start` = 1 for exactly one cycle. Then go to BUSY.
- **BUSY:** wait for `pe_done` = 1, which may be a pulse or a level. On that cycle:
  - Go to LOAD with `idx` = 0.
  - Increment `frame_cnt`; it wraps from all-ones to 0.
- `pe_done` is ignored in LOAD, FLUSH and KICK.
- An `s_valid` word presented while `s_ready` = 0 is not consumed. The source must hold it.

## Timing
- Reset values: state LOAD, `idx` 0, `s_ready` 1, `BRAM_ADDR` 0, `BRAM_WRDATA` 0, `BRAM_WE` 0, `pe_start` 0, `err` 0, `frame_cnt` 0.
- Write latency: handshake in cycle N puts the write on the BRAM port in cycle N+1. It commits at the end of N+1.
- Final handshake in cycle N gives:
  - N+1: FLUSH, `s_ready` 0.
  - N+2: `pe_start` = 1.
  - N+3: BUSY.
- `pe_done` seen in cycle M: `s_ready` = 1 and `frame_cnt` updated in M+1.
- Minimum gap from the last word of one frame to the first word of the next is 4 cycles, when `pe_done` arrives in N+3.
- Throughput in LOAD: one word per cycle with back-to-back `s_valid`.
- `areset` asserted mid-frame: all outputs return immediately to their reset values. The partial frame is discarded; the words already written stay in BRAM and are overwritten by the next frame.

## Configuration
- `PE_LOADER_LAST_CHECK_EN` defined:
  - **Early `s_last`** (handshake with `s_last`=1 and `idx < WORDS-1`): the word is still written. `idx` is reset to 0, the state stays LOAD, and `err` = 1 in the following cycle. The frame restarts at `BASE_ADDR`.
  - **Missing `s_last`** on word `WORDS-1`: `err` = 1 in the following cycle. The frame proceeds normally to FLUSH.
- Undefined:
  - `s_last` is ignored and `err` is tied to 0.
  - Frames are delimited solely by `idx`.

## Test plan
- **Reset values:** hold `areset` high for 5 cycles -> all outputs at reset values, `s_ready` = 1.
- **Nominal frame:** stream 128 words `32'h1000+i` back-to-back, `s_last` on i=127. Required response:
  - `BRAM_ADDR` = `4*i` with `WE` = `4'hF` one cycle after each handshake.
  - `pe_start` pulse exactly 2 cycles after the last handshake.
  - `s_ready` = 0 until `pe_done`; then `frame_cnt` = 1.
- **Backpressure:** present word 0 while in BUSY -> not consumed, and no `WE`. It is written to `BASE_ADDR` in the cycle after `s_ready` returns to 1.
- **Gapped source:** `s_valid` toggling 1/0 -> one write per handshake, addresses contiguous, `WE` = 0 in the idle cycles.
- **Last check** (`PE_LOADER_LAST_CHECK_EN`):
  - `s_last` on word 9 -> `err` pulse; the next word is written to address 0.
  - No `s_last` on word 127 -> `err` pulse and `pe_start` still issued.
- **Mid-frame reset:** assert `areset` after 50 words -> `BRAM_WE` = 0 and the state returns to LOAD. A subsequent full frame starts at address 0, and `frame_cnt` increments from 0 to 1.
